// File: rtl/cla16_adder.sv
// 16-bit two-level carry-lookahead adder with registered outputs (S, Co, V, Pg, Gg).
// Optional macro CLA16_ADDER_INPUT_REG_EN adds an input register stage (2-cycle latency).

module cla4_block (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] c,
  output logic       pb,
  output logic       gb
);

  // c[k] is the carry into bit k of this block; c[0] is the block carry-in
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign pb = &p;
  assign gb = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

module cla16_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Ci,
  output logic [15:0] S,
  output logic        Co,
  output logic        V,
  output logic        Pg,
  output logic        Gg
);

  logic [15:0] a_int;
  logic [15:0] b_int;
  logic        ci_int;

`ifdef CLA16_ADDER_INPUT_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_int  <= 16'h0000;
      b_int  <= 16'h0000;
      ci_int <= 1'b0;
    end else begin
      a_int  <= A;
      b_int  <= B;
      ci_int <= Ci;
    end
  end
`else
  assign a_int  = A;
  assign b_int  = B;
  assign ci_int = Ci;
`endif

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  blk_p;
  logic [3:0]  blk_g;
  logic [3:0]  blk_cin;
  logic        c16;
  logic        grp_g;
  logic [15:0] sum;

  assign p = a_int ^ b_int;
  assign g = a_int & b_int;

  for (genvar k = 0; k < 4; k++) begin : g_blk
    cla4_block u_blk (
      .p   (p[4*k +: 4]),
      .g   (g[4*k +: 4]),
      .cin (blk_cin[k]),
      .c   (c[4*k +: 4]),
      .pb  (blk_p[k]),
      .gb  (blk_g[k])
    );
  end

  // Second-level lookahead: block carry-ins come straight from block P/G and Ci
  assign blk_cin[0] = ci_int;
  assign blk_cin[1] = blk_g[0] | (blk_p[0] & ci_int);
  assign blk_cin[2] = blk_g[1] | (blk_p[1] & blk_g[0]) | (blk_p[1] & blk_p[0] & ci_int);
  assign blk_cin[3] = blk_g[2] | (blk_p[2] & blk_g[1]) | (blk_p[2] & blk_p[1] & blk_g[0])
                    | (blk_p[2] & blk_p[1] & blk_p[0] & ci_int);

  assign grp_g = blk_g[3] | (blk_p[3] & blk_g[2]) | (blk_p[3] & blk_p[2] & blk_g[1])
               | (blk_p[3] & blk_p[2] & blk_p[1] & blk_g[0]);
  assign c16   = grp_g | ((&blk_p) & ci_int);

  assign sum = p ^ c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S  <= 16'h0000;
      Co <= 1'b0;
      V  <= 1'b0;
      Pg <= 1'b0;
      Gg <= 1'b0;
    end else begin
      S  <= sum;
      Co <= c16;
      V  <= c[15] ^ c16;
      Pg <= &blk_p;
      Gg <= grp_g;
    end
  end

endmodule

// File: tb/tb_cla16_adder.sv
// Self-checking bench for cla16_adder: directed vector table, reset sequences and
// randomized vectors against an arithmetic reference model; honours CLA16_ADDER_INPUT_REG_EN.

module tb_cla16_adder;

`ifdef CLA16_ADDER_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        v;
    logic        pg;
    logic        gg;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        Ci;
  logic [15:0] S;
  logic        Co;
  logic        V;
  logic        Pg;
  logic        Gg;

  int compared;
  int mismatched;
  vec_t exp_q[$];

  cla16_adder dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .Ci  (Ci),
    .S   (S),
    .Co  (Co),
    .V   (V),
    .Pg  (Pg),
    .Gg  (Gg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain 17-bit arithmetic plus sign rule for overflow
  function automatic vec_t ref_model(input logic [15:0] a, input logic [15:0] b, input logic ci);
    vec_t r;
    logic [16:0] full;
    logic [16:0] no_ci;
    full  = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
    no_ci = {1'b0, a} + {1'b0, b};
    r.a  = a;
    r.b  = b;
    r.ci = ci;
    r.s  = full[15:0];
    r.co = full[16];
    r.v  = (a[15] == b[15]) && (full[15] != a[15]);
    r.pg = ((a ^ b) == 16'hFFFF);
    r.gg = no_ci[16];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input vec_t e);
    logic [19:0] got;
    logic [19:0] want;
    got  = {S, Co, V, Pg, Gg};
    want = {e.s, e.co, e.v, e.pg, e.gg};
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s A=%h B=%h Ci=%b: got S=%h Co=%b V=%b Pg=%b Gg=%b, want S=%h Co=%b V=%b Pg=%b Gg=%b",
               tag, e.a, e.b, e.ci, S, Co, V, Pg, Gg, e.s, e.co, e.v, e.pg, e.gg);
    end
  endtask

  task automatic checkZero(input string tag);
    vec_t z;
    z = '0;
    checkOutput(tag, z);
  endtask

  // Drive one vector, clock once, and compare the result that is now due
  task automatic applyStimulus(input string tag, input vec_t v);
    vec_t e;
    A  = v.a;
    B  = v.b;
    Ci = v.ci;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    while (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      checkOutput(tag, e);
    end
  endtask

  vec_t table_v[8];

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b0;
    A   = 16'h0000;
    B   = 16'h0000;
    Ci  = 1'b0;

    //            a        b        ci    s        co    v     pg    gg
    table_v[0] = {16'hFF00, 16'h00FF, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    table_v[1] = {16'hFF00, 16'h00FF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    table_v[2] = {16'h03C3, 16'h00CF, 1'b1, 16'h0493, 1'b0, 1'b0, 1'b0, 1'b0};
    table_v[3] = {16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
    table_v[4] = {16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    table_v[5] = {16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
    table_v[6] = {16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    table_v[7] = {16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

    #1 rst = 1'b1;
    #1 checkZero("reset_state");
    @(posedge clk);
    #1 checkZero("reset_held_edge");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("table_%0d", i), table_v[i]);
    end

    // Asynchronous reset mid-cycle while outputs are nonzero
    applyStimulus("pre_reset", ref_model(16'hFFFF, 16'hFFFF, 1'b1));
    for (int i = 0; i < LAT; i++) begin
      applyStimulus("pre_reset_hold", ref_model(16'hFFFF, 16'hFFFF, 1'b1));
    end
    #2 rst = 1'b1;
    #1 checkZero("async_reset_immediate");
    exp_q.delete();
    @(posedge clk);
    #1 checkZero("reset_discard");
    rst = 1'b0;

    // First edges after release must produce correct sums
    applyStimulus("post_reset_1", ref_model(16'h1234, 16'h4321, 1'b1));
    applyStimulus("post_reset_2", ref_model(16'hABCD, 16'h6543, 1'b0));

    for (int i = 0; i < 10000; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = ~a;
        1: a = 16'hFFFF;
        2: begin a = 16'h7FFF; b = 16'($urandom_range(0, 3)); end
        3: begin a = 16'h8000; b = 16'h8000 | 16'($urandom_range(0, 3)); end
        default: ;
      endcase
      applyStimulus("random", ref_model(a, b, ci));
    end

    for (int i = 0; i < LAT; i++) begin
      applyStimulus("drain", ref_model(16'h0000, 16'h0000, 1'b0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cla16_adder.md
CLA16_ADDER -- requirements
Module: cla16_adder

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 16 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 A  input  16  addend A, unsigned or two's complement.
REQ-005 B  input  16  addend B, unsigned or two's complement.
REQ-006 Ci  input  1  carry-in added at bit 0.
REQ-007 S  output  16  registered sum A+B+Ci, modulo 2^16.
REQ-008 Co  output  1  registered carry out of bit 15.
REQ-009 V  output  1  registered signed overflow: carry into bit 15 XOR carry out of bit 15.
REQ-010 Pg  output  1  registered 16-bit group propagate: AND of all bit propagates.
REQ-011 Gg  output  1  registered 16-bit group generate: carry out of bit 15 when Ci=0.

Function
REQ-012 Per-bit terms SHALL be p[i]=A[i] XOR B[i] and g[i]=A[i] AND B[i].
REQ-013 Carries SHALL come from four 4-bit carry-lookahead blocks, each computing its internal carries and a block P/G from its carry-in.
REQ-014 Block carry-ins c4, c8 and c12, and Co, SHALL come from a second-level lookahead unit using the block P/G and Ci, not from ripple between blocks.
REQ-015 Sum bits SHALL be S[i]=p[i] XOR c[i], with c[0]=Ci.
REQ-016 The combinational result SHALL equal A+B+Ci for all 2^33 input combinations.
REQ-017 All outputs SHALL be captured in a register on each rising clk edge when rst is low.
REQ-018 Latency SHALL be 1 cycle: inputs present before edge N appear on outputs after edge N.
REQ-019 There SHALL be no handshake; a new operation is accepted every cycle.
REQ-020 Wrap-around: a result of 2^16 or more SHALL set Co=1 and give S equal to the low 16 bits.
REQ-021 Pg=1 SHALL imply S equals the bitwise inverse of Ci replicated across all bits, with Co=Ci.

Reset
REQ-022 While rst=1, S SHALL be 16'h0000 and Co, V, Pg and Gg SHALL be 0, with no wait for a clock edge.
REQ-023 Reset mid-operation SHALL discard any captured result.
REQ-024 After rst deasserts, the first rising edge SHALL capture the current inputs normally.

Configuration
REQ-025 With macro CLA16_ADDER_INPUT_REG_EN defined, A, B and Ci SHALL first be registered, giving 2-cycle latency.
REQ-026 Under CLA16_ADDER_INPUT_REG_EN, the input register SHALL also clear to 0 on rst.
REQ-027 Without CLA16_ADDER_INPUT_REG_EN, the adder SHALL be combinational from the ports into the output register, giving 1-cycle latency.

Verification
REQ-028 A=16'hFF00, B=16'h00FF, Ci=0 -> S=16'hFFFF, Co=0, V=0, Pg=1, Gg=0.
REQ-029 A=16'hFF00, B=16'h00FF, Ci=1 -> S=16'h0000, Co=1, V=0, Pg=1.
REQ-030 A=16'h03C3, B=16'h00CF, Ci=1 -> S=16'h0493, Co=0, V=0.
REQ-031 A=16'h7FFF, B=16'h0001, Ci=0 -> S=16'h8000, Co=0, V=1; and A=B=16'hFFFF, Ci=1 -> S=16'hFFFF, Co=1, Gg=1.
REQ-032 Assert rst between clock edges while outputs are nonzero -> all outputs 0 immediately.
REQ-033 After reset release, the first edge SHALL produce a correct sum.
REQ-034 Random stimulus of at least 10,000 vectors -> outputs match a reference A+B+Ci delayed by the configured latency, in both macro settings.
